seg_monitor: RTL and testbench

Receive-side checker for the seven-segment display path: it samples the 8-bit segment bus driven by the hex decoder and waits until each pattern has been stable long enough. It then decodes the pattern back to a 4-bit hex digit and checks that successive digits follow the counter's mod-16 up-count. It sits beside the counter/decoder top level as a self-check block for board bring-up and simulation. It flags illegal patterns and sequence breaks, and keeps a saturating error count.

---
 rtl/seg_monitor.sv | 182 ++++++++++++++++++
 tb/tb_seg_monitor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_monitor.sv
// rtl/seg_monitor.sv - seven-segment receive-side checker with stability filter and sequence check
//
// Purpose:
//   Watches the segment bus, waits for each pattern to sit still for
//   STABLE_CYCLES samples, decodes it back to a hex digit and checks that
//   digits arrive in mod-16 up-count order. Illegal glyphs and sequence
//   breaks are flagged and counted (saturating).
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   seg_in[7:0]  segment bus {dp,g,f,e,d,c,b,a}, 1 = lit; dp is ignored
//   clr_err      synchronous clear of err_count (wins over an increment)
//   digit_out    last accepted legal digit
//   digit_valid  1-cycle pulse, new legal digit accepted
//   invalid      1-cycle pulse, stable non-blank pattern is not a hex glyph
//   seq_err      1-cycle pulse, accepted digit is not last+1 mod 16
//   err_count    saturating count of invalid + seq_err events
//   locked       high once the first legal digit has been accepted

module seg_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       seg_in,
  input  logic             clr_err,
  output logic [3:0]       digit_out,
  output logic             digit_valid,
  output logic             invalid,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_count,
  output logic             locked
);

  localparam logic [7:0] RUN_MAX = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    ACCEPT = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t     r_state;
  logic [6:0] r_s;
  logic [7:0] r_run;
  logic [6:0] r_last_pat;
  logic [3:0] r_last_dig;

  logic       w_changed;
  logic [7:0] w_run_next;
  logic       w_legal;
  logic [3:0] w_dig;
  logic [3:0] w_expect;
  logic       w_new_pat;
  logic       w_err_event;

  // dp (bit 7) is masked out of the comparison; only {g..a} matter.
  always_comb begin
    w_changed = ((seg_in ^ {1'b0, r_s}) & 8'h7F) != 8'h00;
  end

  // Run length of identical samples, saturating at STABLE_CYCLES.
  always_comb begin
    if (w_changed) begin
      w_run_next = 8'd1;
    end else if (r_run == RUN_MAX) begin
      w_run_next = RUN_MAX;
    end else begin
      w_run_next = r_run + 8'd1;
    end
  end

  // Glyph decoder on the captured pattern.
  always_comb begin
    w_legal = 1'b1;
    w_dig   = 4'h0;
    case (r_s)
      7'h3F: w_dig = 4'h0;
      7'h06: w_dig = 4'h1;
      7'h5B: w_dig = 4'h2;
      7'h4F: w_dig = 4'h3;
      7'h66: w_dig = 4'h4;
      7'h6D: w_dig = 4'h5;
      7'h7D: w_dig = 4'h6;
      7'h07: w_dig = 4'h7;
      7'h7F: w_dig = 4'h8;
      7'h6F: w_dig = 4'h9;
      7'h77: w_dig = 4'hA;
      7'h7C: w_dig = 4'hB;
      7'h39: w_dig = 4'hC;
      7'h5E: w_dig = 4'hD;
      7'h79: w_dig = 4'hE;
      7'h71: w_dig = 4'hF;
      default: w_legal = 1'b0;
    endcase
  end

  // 4-bit add wraps F -> 0, which is the legal rollover.
  always_comb begin
    w_expect = r_last_dig + 4'd1;
  end

  // A pattern equal to the last accepted one (e.g. after a short glitch)
  // is not new and must stay silent; blank is never an event.
  always_comb begin
    w_new_pat   = (r_state == ACCEPT) && (r_s != r_last_pat);
    w_err_event = w_new_pat && (r_s != 7'h00) &&
                  (!w_legal || (locked && (w_dig != w_expect)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= SETTLE;
      r_s         <= 7'h00;
      r_run       <= 8'd0;
      r_last_pat  <= 7'h00;
      r_last_dig  <= 4'h0;
      digit_out   <= 4'h0;
      digit_valid <= 1'b0;
      invalid     <= 1'b0;
      seq_err     <= 1'b0;
      err_count   <= '0;
      locked      <= 1'b0;
    end else begin
      r_s         <= seg_in[6:0];
      r_run       <= w_run_next;
      digit_valid <= 1'b0;
      invalid     <= 1'b0;
      seq_err     <= 1'b0;

      case (r_state)
        // Move to ACCEPT on the edge the run reaches its target so the
        // evaluation edge lands STABLE_CYCLES edges after the change.
        SETTLE: begin
          if (w_run_next == RUN_MAX) begin
            r_state <= ACCEPT;
          end
        end

        ACCEPT: begin
          r_state <= HOLD;
          if (w_new_pat) begin
            r_last_pat <= r_s;
            if (r_s != 7'h00) begin
              if (w_legal) begin
                digit_out   <= w_dig;
                digit_valid <= 1'b1;
                r_last_dig  <= w_dig;
                if (!locked) begin
                  locked <= 1'b1;
                end else if (w_dig != w_expect) begin
                  seq_err <= 1'b1;
                end
              end else begin
                invalid <= 1'b1;
              end
            end
          end
        end

        // A change that landed during ACCEPT shows up as a short run
        // rather than a mismatch, so both are treated as leaving HOLD.
        HOLD: begin
          if (w_changed || (r_run != RUN_MAX)) begin
            r_state <= SETTLE;
          end
        end

        default: r_state <= SETTLE;
      endcase

      if (clr_err) begin
        err_count <= '0;
      end else if (w_err_event && (err_count != '1)) begin
        err_count <= err_count + ERR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seg_monitor.sv
// tb/tb_seg_monitor.sv - table-driven scoreboard bench for seg_monitor

module tb_seg_monitor;

  localparam int STABLE = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] seg_in;
  logic       clr_err;
  logic [3:0] digit_out;
  logic       digit_valid;
  logic       invalid;
  logic       seq_err;
  logic [7:0] err_count;
  logic       locked;

  seg_monitor #(.STABLE_CYCLES(STABLE), .ERR_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .clr_err     (clr_err),
    .digit_out   (digit_out),
    .digit_valid (digit_valid),
    .invalid     (invalid),
    .seq_err     (seq_err),
    .err_count   (err_count),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] seg;
    int         hold;
    logic       v;
    logic       inv;
    logic       se;
    logic [3:0] dig;
    logic [7:0] err;
    logic       lck;
  } vec_t;

  typedef struct {
    int         at;
    logic       v;
    logic       inv;
    logic       se;
    logic [3:0] dig;
    logic [7:0] err;
    logic       lck;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] seg, input int hold, input logic v,
                              input logic inv, input logic se, input logic [3:0] dig,
                              input logic [7:0] err, input logic lck);
    vec_t r;
    r.seg = seg; r.hold = hold; r.v = v; r.inv = inv; r.se = se;
    r.dig = dig; r.err = err; r.lck = lck;
    return r;
  endfunction

  // Called at a negedge. The pulse for a pattern set here is visible at the
  // negedge following edge (first sampling edge + STABLE).
  task automatic drive(input vec_t r, input int clr_idx);
    exp_t e;
    seg_in = r.seg;
    if (r.v || r.inv || r.se) begin
      e.at = cyc + 1 + STABLE;
      e.v = r.v; e.inv = r.inv; e.se = r.se;
      e.dig = r.dig; e.err = r.err; e.lck = r.lck;
      sb.push_back(e);
    end
    for (int i = 0; i < r.hold; i++) begin
      clr_err = (i == clr_idx);
      @(negedge clk);
    end
    clr_err = 1'b0;
  endtask

  // Scoreboard consumer: every pulse cycle must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (digit_valid || invalid || seq_err) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", {29'd0, digit_valid, invalid, seq_err}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("pulse_cycle", cyc, e.at);
          chk("digit_valid", digit_valid, e.v);
          chk("invalid", invalid, e.inv);
          chk("seq_err", seq_err, e.se);
          chk("digit_out", digit_out, e.dig);
          chk("err_count", err_count, e.err);
          chk("locked", locked, e.lck);
        end
      end else if (sb.size() > 0 && cyc > sb[0].at) begin
        e = sb.pop_front();
        chk("missing_pulse_at", cyc, e.at);
      end
    end
  end

  vec_t tbl[25];
  vec_t r;
  int   e_cnt;

  initial begin
    rst = 1'b1;
    seg_in = 8'h00;
    clr_err = 1'b0;

    tbl[0]  = mk(8'h00, 20, 0, 0, 0, 4'h0, 8'd0, 0);
    tbl[1]  = mk(8'hBF, 10, 1, 0, 0, 4'h0, 8'd0, 1);
    tbl[2]  = mk(8'h86, 10, 1, 0, 0, 4'h1, 8'd0, 1);
    tbl[3]  = mk(8'h5B, 10, 1, 0, 0, 4'h2, 8'd0, 1);
    tbl[4]  = mk(8'h4F, 10, 1, 0, 0, 4'h3, 8'd0, 1);
    tbl[5]  = mk(8'h79, 10, 1, 0, 1, 4'hE, 8'd1, 1);
    tbl[6]  = mk(8'h71, 10, 1, 0, 0, 4'hF, 8'd1, 1);
    tbl[7]  = mk(8'h3F, 10, 1, 0, 0, 4'h0, 8'd1, 1);
    tbl[8]  = mk(8'h5B, 10, 1, 0, 1, 4'h2, 8'd2, 1);
    tbl[9]  = mk(8'h4F, 10, 1, 0, 0, 4'h3, 8'd2, 1);
    tbl[10] = mk(8'h66, 10, 1, 0, 0, 4'h4, 8'd2, 1);
    tbl[11] = mk(8'h7F,  2, 0, 0, 0, 4'h4, 8'd2, 1);
    tbl[12] = mk(8'h66, 10, 0, 0, 0, 4'h4, 8'd2, 1);
    tbl[13] = mk(8'h49, 10, 0, 1, 0, 4'h4, 8'd3, 1);
    tbl[14] = mk(8'h00, 10, 0, 0, 0, 4'h4, 8'd3, 1);
    tbl[15] = mk(8'hC9, 10, 0, 1, 0, 4'h4, 8'd4, 1);
    tbl[16] = mk(8'h6D, 10, 1, 0, 0, 4'h5, 8'd4, 1);
    tbl[17] = mk(8'h7D,  3, 0, 0, 0, 4'h5, 8'd4, 1);
    tbl[18] = mk(8'h07, 10, 1, 0, 1, 4'h7, 8'd5, 1);
    tbl[19] = mk(8'h7F, 10, 1, 0, 0, 4'h8, 8'd5, 1);
    tbl[20] = mk(8'h6F, 10, 1, 0, 0, 4'h9, 8'd5, 1);
    tbl[21] = mk(8'h77, 10, 1, 0, 0, 4'hA, 8'd5, 1);
    tbl[22] = mk(8'h7C, 10, 1, 0, 0, 4'hB, 8'd5, 1);
    tbl[23] = mk(8'h39, 10, 1, 0, 0, 4'hC, 8'd5, 1);
    tbl[24] = mk(8'hDE, 10, 1, 0, 0, 4'hD, 8'd5, 1);

    repeat (3) @(negedge clk);
    chk("rst_digit_out", digit_out, 4'h0);
    chk("rst_pulses", {digit_valid, invalid, seq_err}, 3'b000);
    chk("rst_err_count", err_count, 8'd0);
    chk("rst_locked", locked, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i], -1);
      if (i == 0) begin
        chk("blank_locked", locked, 1'b0);
        chk("blank_err_count", err_count, 8'd0);
      end
    end

    // Saturation: alternate two illegal glyphs until err_count pins at FF.
    e_cnt = 5;
    for (int i = 0; i < 252; i++) begin
      e_cnt = (e_cnt == 255) ? 255 : e_cnt + 1;
      drive(mk((i % 2 == 0) ? 8'h49 : 8'h4A, 6, 0, 1, 0, 4'hD, 8'(e_cnt), 1), -1);
    end
    chk("err_saturated", err_count, 8'hFF);

    // clr_err on the same edge as an invalid event: clear wins.
    drive(mk(8'h49, 10, 0, 1, 0, 4'hD, 8'd0, 1), 4);
    drive(mk(8'h4A, 10, 0, 1, 0, 4'hD, 8'd1, 1), -1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("clr_alone", err_count, 8'd0);

    // Mid-run reset while holding digit 7.
    drive(mk(8'h07, 10, 1, 0, 1, 4'h7, 8'd1, 1), -1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_digit_out", digit_out, 4'h0);
    chk("async_rst_locked", locked, 1'b0);
    chk("async_rst_err_count", err_count, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(mk(8'h66, 10, 1, 0, 0, 4'h4, 8'd0, 1), -1);

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
